// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - Execute-stage multiply/divide unit owning the HI/LO registers
// Results land in HI/LO after a fixed busy window; MTHI/MTLO write immediately.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [3:0]  count;
    logic [31:0] pending_hi;
    logic [31:0] pending_lo;

    logic        accept;
    logic        mul_signed;
    logic        div_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    assign accept     = Start && !Busy;
    assign mul_signed = (Op == OP_MULT);
    assign div_signed = (Op == OP_DIV);

    // Sign-extending to 64 bits lets one unsigned multiplier serve both forms.
    always_comb begin
        mul_a   = mul_signed ? {{32{A[31]}}, A} : {32'd0, A};
        mul_b   = mul_signed ? {{32{B[31]}}, B} : {32'd0, B};
        product = mul_a * mul_b;
    end

    // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    always_comb begin
        a_neg     = div_signed && A[31];
        b_neg     = div_signed && B[31];
        a_mag     = a_neg ? (32'd0 - A) : A;
        b_mag     = b_neg ? (32'd0 - B) : B;
        b_safe    = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag     = a_mag / b_safe;
        r_mag     = a_mag % b_safe;
        quotient  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        remainder = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count      <= 4'd0;
            Busy       <= 1'b0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
            HI         <= 32'd0;
            LO         <= 32'd0;
        end else if (accept) begin
            case (Op)
                OP_MULT, OP_MULTU: begin
                    pending_hi <= product[63:32];
                    pending_lo <= product[31:0];
                    count      <= MULT_LOAD;
                    Busy       <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    // Divide by zero still burns the full latency but leaves HI/LO alone.
                    pending_hi <= (B == 32'd0) ? HI : remainder;
                    pending_lo <= (B == 32'd0) ? LO : quotient;
                    count      <= DIV_LOAD;
                    Busy       <= 1'b1;
                end
                OP_MTHI: HI <= A;
                OP_MTLO: LO <= A;
                default: ;
            endcase
        end else if (count == 4'd1) begin
            HI    <= pending_hi;
            LO    <= pending_lo;
            count <= 4'd0;
            Busy  <= 1'b0;
        end else if (count != 4'd0) begin
            count <= count - 4'd1;
        end
    end

endmodule
